// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles,
// reports a generator-style duty code and flags a stuck input after a timeout.
module pwm_capture #(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned PWM_FREQ    = 20000,
  parameter int unsigned WL          = $clog2(CLK_FREQ / PWM_FREQ),
  parameter int unsigned TIMEOUT_CNT = 2 * (CLK_FREQ / PWM_FREQ),
  parameter int unsigned CW          = $clog2(TIMEOUT_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pwm,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high_time,
  output logic [WL-1:0] o_duty_cycle,
  output logic          o_valid,
  output logic          o_stuck,
  output logic          o_level
);

  localparam int unsigned DW = (CW > WL) ? CW : WL;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT_CNT);
  localparam logic [DW-1:0] DUTY_MAX = DW'({WL{1'b1}});

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            s1;
  logic            s2;
  logic            d;
  logic            rise_c;
  logic            timeout_c;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   hi;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   hi_d;
  logic [DW-1:0]   hm1;
  logic [WL-1:0]   duty_c;

  assign rise_c    = s2 & ~d;
  // A rise in the timeout cycle takes priority: the measurement is still valid.
  assign timeout_c = (cnt == TO_VAL) && !rise_c;

  // Two-flop synchronizer followed by the edge-detect delay register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= i_pwm;
      s2 <= s1;
      d  <= s2;
    end
  end

  always_comb begin
    cnt_d = cnt;
    hi_d  = hi;
    if (rise_c) begin
      cnt_d = CW'(1);
      hi_d  = CW'(1);
    end else begin
      if (cnt != TO_VAL && cnt != CNT_MAX) cnt_d = cnt + CW'(1);
      if (s2 && hi != CNT_MAX)             hi_d  = hi + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      hi  <= '0;
    end else begin
      cnt <= cnt_d;
      hi  <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise_c)    state_d = MEASURE;
      MEASURE: if (timeout_c) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Duty code is high time minus one, saturated to the duty-code width.
  always_comb begin
    hm1    = DW'(hi) - DW'(1);
    duty_c = '0;
    if (hi != '0) duty_c = (hm1 > DUTY_MAX) ? WL'(DUTY_MAX) : WL'(hm1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_period     <= '0;
      o_high_time  <= '0;
      o_duty_cycle <= '0;
      o_valid      <= 1'b0;
      o_stuck      <= 1'b0;
      o_level      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (rise_c) begin
        o_stuck <= 1'b0;
        if (state_q == MEASURE) begin
          o_period     <= cnt;
          o_high_time  <= hi;
          o_duty_cycle <= duty_c;
          o_valid      <= 1'b1;
        end
      end else if (timeout_c) begin
        if (!o_stuck) o_level <= s2;
        o_stuck      <= 1'b1;
        o_period     <= '0;
        o_high_time  <= '0;
        o_duty_cycle <= '0;
      end
    end
  end

endmodule
